// File: rtl/alu_pkg.sv
// Shared constants and mode encoding for the 4-bit ALU datapath blocks.
package alu_pkg;

    localparam int WIDTH    = 4;
    localparam int SEL_W    = 3;
    localparam int CHANNELS = 8;

    // MANUAL: destination comes from in_sel. SCAN: destination comes from the scan pointer.
    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } mode_e;

endpackage

// File: rtl/demux_slot.sv
// Single-entry output slot: holds one word until its consumer acknowledges it.
// A write in the same cycle as an ack wins, so the slot can be refilled at full rate.
module demux_slot
    import alu_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic         ack,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    logic [W-1:0] q_q, q_d;
    logic         valid_q, valid_d;

    // Next-state: write beats ack; an ack alone empties the slot but keeps the data.
    always_comb begin
        q_d     = q_q;
        valid_d = valid_q;
        if (wr_en) begin
            q_d     = d;
            valid_d = 1'b1;
        end else if (ack) begin
            valid_d = 1'b0;
        end
    end

    // Slot storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
        end
    end

    assign q     = q_q;
    assign valid = valid_q;

endmodule

// File: rtl/demux_reg8.sv
// Registered 1-to-8 demultiplexer with manual select or round-robin scan mode.
//
// Handshake: a word is accepted at a rising edge when in_valid & in_ready.
// in_ready is high when the target slot is empty or is being acknowledged in
// the same cycle. While stalled the producer holds in_data/in_sel stable.
// The slot consumer takes slot k when out_valid[k] & out_ack[k].
module demux_reg8
    import alu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      auto_mode,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ack,
    output logic [SEL_W-1:0]          scan_ptr,
    output logic                      frame_done
);

    mode_e               mode_q, mode_d;
    logic [SEL_W-1:0]    scan_ptr_q, scan_ptr_d;
    logic                frame_done_q, frame_done_d;
    logic [SEL_W-1:0]    eff_ptr;
    logic [SEL_W-1:0]    tgt;
    logic                accept;
    logic [CHANNELS-1:0] wr_en;

    // Target decode and ready mux. On the cycle SCAN is entered the pointer
    // is treated as 0 so a stale value from an earlier scan is never used.
    always_comb begin
        eff_ptr  = (mode_q == SCAN) ? scan_ptr_q : '0;
        tgt      = auto_mode ? eff_ptr : in_sel;
        in_ready = !out_valid[tgt] | out_ack[tgt];
        accept   = in_valid & in_ready;
        wr_en    = '0;
        if (accept) begin
            wr_en[tgt] = 1'b1;
        end
    end

    // Mode / scan-pointer next state: advance once per accept in SCAN,
    // pulse frame_done when the last slot of a frame is written.
    always_comb begin
        mode_d       = auto_mode ? SCAN : MANUAL;
        scan_ptr_d   = scan_ptr_q;
        frame_done_d = 1'b0;
        if (auto_mode) begin
            scan_ptr_d   = eff_ptr + SEL_W'(accept);
            frame_done_d = accept & (eff_ptr == SEL_W'(CHANNELS - 1));
        end
    end

    // Mode FSM state, scan pointer and frame pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= MANUAL;
            scan_ptr_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            scan_ptr_q   <= scan_ptr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign scan_ptr   = scan_ptr_q;
    assign frame_done = frame_done_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
        demux_slot #(
            .W(WIDTH)
        ) u_slot (
            .clk  (clk),
            .rst_n(rst_n),
            .wr_en(wr_en[k]),
            .ack  (out_ack[k]),
            .d    (in_data),
            .q    (out_data[k*WIDTH +: WIDTH]),
            .valid(out_valid[k])
        );
    end

endmodule

// File: tb/tb_demux_reg8.sv
// Bench for demux_reg8: directed scenarios followed by randomized traffic,
// every cycle compared against a slot-level behavioural model.
module tb_demux_reg8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_data;
    logic [2:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic        auto_mode;
    logic [31:0] out_data;
    logic [7:0]  out_valid;
    logic [7:0]  out_ack;
    logic [2:0]  scan_ptr;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Behavioural model: eight mailboxes, a scan position and the mode seen last cycle.
    logic [3:0] m_data [8];
    logic [7:0] m_valid;
    int         m_ptr;
    logic       m_scan;
    logic       m_fd;

    demux_reg8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .auto_mode (auto_mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .scan_ptr  (scan_ptr),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_data[k] = 4'h0;
        m_valid = 8'h00;
        m_ptr   = 0;
        m_scan  = 1'b0;
        m_fd    = 1'b0;
    endtask

    // Destination slot: in_sel manually; in scan mode the scan position,
    // which restarts at 0 when scan mode is freshly entered.
    function automatic int model_tgt();
        if (!auto_mode) return int'(in_sel);
        return m_scan ? m_ptr : 0;
    endfunction

    function automatic logic model_ready();
        int t = model_tgt();
        return !m_valid[t] || out_ack[t];
    endfunction

    function automatic logic [31:0] model_data();
        logic [31:0] v = '0;
        for (int k = 0; k < 8; k++) v[k*4 +: 4] = m_data[k];
        return v;
    endfunction

    task automatic model_edge();
        int   t   = model_tgt();
        logic acc = in_valid && model_ready();
        for (int k = 0; k < 8; k++) begin
            if (acc && k == t) begin
                m_data[k]  = in_data;
                m_valid[k] = 1'b1;
            end else if (out_ack[k]) begin
                m_valid[k] = 1'b0;
            end
        end
        if (auto_mode) begin
            m_fd  = acc && (t == 7);
            m_ptr = acc ? (t + 1) % 8 : t;
        end else begin
            m_fd = 1'b0;
        end
        m_scan = auto_mode;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, "/out_data"}, out_data, model_data());
        chk({tag, "/scan_ptr"}, 32'(scan_ptr), 32'(m_ptr));
        chk({tag, "/frame_done"}, 32'(frame_done), 32'(m_fd));
    endtask

    // One clock: inputs were set at the falling edge; check ready, clock, check state.
    task automatic step(input string tag);
        #1;
        chk({tag, "/in_ready"}, 32'(in_ready), 32'(model_ready()));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [3:0] d,
                         input logic [7:0] a, input logic am);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ack   = a;
        auto_mode = am;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 4'h0, 8'h00, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Manual routing.
        drive(1'b1, 3'd3, 4'hA, 8'h00, 1'b0);
        step("man3");
        chk("man3/slot3", 32'(out_data[15:12]), 32'hA);
        drive(1'b1, 3'd6, 4'h5, 8'h00, 1'b0);
        step("man6");
        chk("man6/valid", 32'(out_valid), 32'h48);
        chk("man6/slot6", 32'(out_data[27:24]), 32'h5);

        // Backpressure, then same-cycle ack refill.
        drive(1'b1, 3'd3, 4'hC, 8'h00, 1'b0);
        #1 chk("bp/ready_low", 32'(in_ready), 32'h0);
        step("bp");
        chk("bp/slot3_held", 32'(out_data[15:12]), 32'hA);
        drive(1'b1, 3'd3, 4'hC, 8'h08, 1'b0);
        #1 chk("bypass/ready_high", 32'(in_ready), 32'h1);
        step("bypass");
        chk("bypass/slot3", 32'(out_data[15:12]), 32'hC);
        chk("bypass/valid3", 32'(out_valid[3]), 32'h1);

        // Ack without write; ack on an empty slot.
        drive(1'b0, 3'd0, 4'h0, 8'h40, 1'b0);
        step("ack6");
        chk("ack6/valid6", 32'(out_valid[6]), 32'h0);
        chk("ack6/slot6", 32'(out_data[27:24]), 32'h5);
        drive(1'b0, 3'd0, 4'h0, 8'h01, 1'b0);
        step("ack0_empty");
        chk("ack0_empty/valid", 32'(out_valid), 32'h08);

        // Auto scan: empty everything, enter SCAN, stream eight words.
        drive(1'b0, 3'd0, 4'h0, 8'hFF, 1'b0);
        step("clear1");
        drive(1'b0, 3'd0, 4'h0, 8'h00, 1'b1);
        step("scan_enter");
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'd0, 4'(k), 8'h00, 1'b1);
            step("scan_word");
        end
        chk("scan/all_full", 32'(out_valid), 32'hFF);
        chk("scan/slots", out_data, 32'h7654_3210);
        chk("scan/ptr_wrap", 32'(scan_ptr), 32'h0);
        chk("scan/frame_done", 32'(frame_done), 32'h1);
        drive(1'b1, 3'd0, 4'h8, 8'h00, 1'b1);
        #1 chk("scan9/ready_low", 32'(in_ready), 32'h0);
        step("scan9_stall");
        chk("scan9/frame_done_low", 32'(frame_done), 32'h0);
        step("scan9_stall2");
        drive(1'b1, 3'd0, 4'h8, 8'h01, 1'b1);
        step("scan9_ack");
        chk("scan9/slot0", 32'(out_data[3:0]), 32'h8);
        chk("scan9/ptr", 32'(scan_ptr), 32'h1);

        // Mode switch: advance to pointer 4, go manual, come back.
        drive(1'b0, 3'd0, 4'h0, 8'hFF, 1'b1);
        step("clear2");
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3'd0, 4'(k + 9), 8'h00, 1'b1);
            step("adv");
        end
        chk("adv/ptr4", 32'(scan_ptr), 32'h4);
        drive(1'b0, 3'd0, 4'h0, 8'hFF, 1'b1);
        step("clear3");
        drive(1'b1, 3'd1, 4'hE, 8'h00, 1'b0);
        step("manual_sel1");
        chk("manual/ptr_held", 32'(scan_ptr), 32'h4);
        chk("manual/slot1", 32'(out_data[7:4]), 32'hE);
        drive(1'b0, 3'd0, 4'h0, 8'h00, 1'b1);
        step("reenter");
        drive(1'b1, 3'd5, 4'h3, 8'h00, 1'b1);
        step("reenter_word");
        chk("reenter/slot0", 32'(out_data[3:0]), 32'h3);
        chk("reenter/valid0", 32'(out_valid[0]), 32'h1);
        chk("reenter/ptr", 32'(scan_ptr), 32'h1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic am;
            am = (n % 40 < 20) ? 1'b1 : 1'b0;
            if ($urandom_range(15) == 0) am = ~am;
            drive(1'($urandom_range(1)), 3'($urandom_range(7)), 4'($urandom_range(15)),
                  8'($urandom) & 8'($urandom), am);
            step("rand");
        end

        // Asynchronous reset with slots 2 and 5 full.
        drive(1'b0, 3'd0, 4'h0, 8'hFF, 1'b0);
        step("pre_rst_clear");
        drive(1'b1, 3'd2, 4'h7, 8'h00, 1'b0);
        step("fill2");
        drive(1'b1, 3'd5, 4'h9, 8'h00, 1'b0);
        step("fill5");
        chk("fill/valid", 32'(out_valid), 32'h24);
        drive(1'b0, 3'd0, 4'h0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst/valid", 32'(out_valid), 32'h0);
        chk("async_rst/data", out_data, 32'h0);
        chk("async_rst/ptr", 32'(scan_ptr), 32'h0);
        chk("async_rst/fd", 32'(frame_done), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 3'd4, 4'h6, 8'h00, 1'b0);
        step("post_rst");
        chk("post_rst/slot4", 32'(out_data[19:16]), 32'h6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
